// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte streams, transmitter start/busy handshake and arbiter status.
// master is the arbiter side; slave is the requester/transmitter side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   i_req_valid;
  logic [8*NUM_REQ-1:0] i_req_data;
  logic [NUM_REQ-1:0]   i_req_last;
  logic [NUM_REQ-1:0]   o_req_ready;
  logic [7:0]           o_tx_data;
  logic                 o_tx_strobe;
  logic                 i_tx_busy;
  logic [NUM_REQ-1:0]   o_grant;
  logic                 o_active;

  modport master (
    input  i_req_valid, i_req_data, i_req_last, i_tx_busy,
    output o_req_ready, o_tx_data, o_tx_strobe, o_grant, o_active
  );

  modport slave (
    output i_req_valid, i_req_data, i_req_last, i_tx_busy,
    input  o_req_ready, o_tx_data, o_tx_strobe, o_grant, o_active
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte streams with round-robin packet grants.
// Define UART_TX_ARB_BURST_LIMIT_EN to also end a grant after MAX_BURST accepted bytes.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input logic               i_uart_clk,
  input logic               i_reset,
  uart_tx_arbiter_if.master bus
);
  localparam int IdxW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_START, WAIT_DONE} state_e;

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1) begin : gBadParams
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and MAX_BURST at least 1");
  end

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic [IdxW-1:0]     rrPtr_q, rrPtr_d;
  logic [7:0]          txData_q, txData_d;
  logic                strobe_q, strobe_d;
  logic                last_q, last_d;

  logic                pickFound;
  logic [IdxW-1:0]     pickIdx;
  logic [IdxW-1:0]     cand;
  logic                sendOk;
  logic                handshake;
  logic                ownerValid;
  logic                ownerLast;
  logic [7:0]          ownerData;
  logic                grantEnd;

  // First valid requester at or above rrPtr_q, wrapping around.
  always_comb begin
    pickFound = 1'b0;
    pickIdx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IdxW'((int'(rrPtr_q) + i) % NUM_REQ);
      if (!pickFound && bus.i_req_valid[cand]) begin
        pickFound = 1'b1;
        pickIdx   = cand;
      end
    end
  end

  always_comb begin
    ownerData = 8'h00;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) begin
        ownerData = bus.i_req_data[8*k +: 8];
      end
    end
  end

  assign ownerValid = |(bus.i_req_valid & grant_q);
  assign ownerLast  = |(bus.i_req_last & grant_q);
  assign sendOk     = (state_q == SEND) && !bus.i_tx_busy;
  assign handshake  = sendOk && ownerValid;

`ifdef UART_TX_ARB_BURST_LIMIT_EN
  localparam int BurstW = $clog2(MAX_BURST + 1);

  logic [BurstW-1:0] burst_q, burst_d;

  // Saturating count of bytes accepted under the current grant.
  always_comb begin
    burst_d = burst_q;
    if (state_q == IDLE && pickFound) begin
      burst_d = '0;
    end else if (handshake && burst_q != BurstW'(MAX_BURST)) begin
      burst_d = burst_q + 1'b1;
    end
  end

  always_ff @(posedge i_uart_clk or posedge i_reset) begin
    if (i_reset) begin
      burst_q <= '0;
    end else begin
      burst_q <= burst_d;
    end
  end

  assign grantEnd = last_q || (burst_q == BurstW'(MAX_BURST));
`else
  assign grantEnd = last_q;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rrPtr_d  = rrPtr_q;
    txData_d = txData_q;
    strobe_d = 1'b0;
    last_d   = last_q;
    unique case (state_q)
      IDLE: begin
        if (pickFound) begin
          grant_d          = '0;
          grant_d[pickIdx] = 1'b1;
          owner_d          = pickIdx;
          state_d          = SEND;
        end
      end
      SEND: begin
        if (handshake) begin
          txData_d = ownerData;
          strobe_d = 1'b1;
          last_d   = ownerLast;
          state_d  = WAIT_START;
        end
      end
      WAIT_START: begin
        if (bus.i_tx_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!bus.i_tx_busy) begin
          if (grantEnd) begin
            grant_d = '0;
            rrPtr_d = (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
            state_d = IDLE;
          end else begin
            state_d = SEND;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_uart_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rrPtr_q  <= '0;
      txData_q <= 8'h00;
      strobe_q <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rrPtr_q  <= rrPtr_d;
      txData_q <= txData_d;
      strobe_q <= strobe_d;
      last_q   <= last_d;
    end
  end

  assign bus.o_req_ready = sendOk ? grant_q : '0;
  assign bus.o_tx_data   = txData_q;
  assign bus.o_tx_strobe = strobe_q;
  assign bus.o_grant     = grant_q;
  assign bus.o_active    = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized bench; the expected strobe order comes from a packet-level
// round-robin model over per-requester byte queues, with a simple busy-pulse transmitter model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int NR = 4;
`ifdef UART_TX_ARB_BURST_LIMIT_EN
  localparam int MB      = 4;
  localparam bit BurstEn = 1'b1;
`else
  localparam int MB      = 16;
  localparam bit BurstEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .i_uart_clk(clk),
    .i_reset   (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0]    reqBytes[NR][$];
  bit            reqLasts[NR][$];
  bit            reqEn[NR];
  logic [7:0]    expData[$];
  logic [NR-1:0] expGrant[$];
  logic [NR-1:0] obsGrant[$];
  int            modelPtr;
  int            strobeCount;
  int            txDelay, txLen, txWait, txBusyLeft;
  bit            txForce;
  bit            prevStrobe;
  logic [NR-1:0] lastHs;

  // Present the head of each requester queue and the transmitter busy level.
  task automatic applyStimulus();
    for (int k = 0; k < NR; k++) begin
      bus.i_req_valid[k]       = reqEn[k] && (reqBytes[k].size() > 0);
      bus.i_req_data[8*k +: 8] = (reqBytes[k].size() > 0) ? reqBytes[k][0] : 8'h00;
      bus.i_req_last[k]        = (reqLasts[k].size() > 0) ? reqLasts[k][0] : 1'b0;
    end
    bus.i_tx_busy = txForce || (txBusyLeft > 0);
  endtask

  // One clock: sample the handshake before the edge, then monitor strobes and step the transmitter.
  task automatic tick();
    logic [7:0]    ed;
    logic [NR-1:0] eg;
    #2;
    lastHs = bus.i_req_valid & bus.o_req_ready;
    @(posedge clk);
    #1;
    for (int k = 0; k < NR; k++) begin
      if (lastHs[k]) begin
        void'(reqBytes[k].pop_front());
        void'(reqLasts[k].pop_front());
      end
    end
    if (bus.o_tx_strobe === 1'b1) begin
      strobeCount++;
      obsGrant.push_back(bus.o_grant);
      assertCount++;
      if (bus.i_tx_busy === 1'b1 || prevStrobe) begin
        failCount++;
        $display("[TB] FAIL strobe_protocol: strobe seen with busy=%b prevStrobe=%b, required busy=0 prevStrobe=0",
                 bus.i_tx_busy, prevStrobe);
      end
      assertCount++;
      if (expData.size() == 0) begin
        failCount++;
        $display("[TB] FAIL unexpected_strobe: data=%h grant=%b, required no strobe", bus.o_tx_data, bus.o_grant);
      end else begin
        ed = expData.pop_front();
        eg = expGrant.pop_front();
        if (bus.o_tx_data !== ed || bus.o_grant !== eg) begin
          failCount++;
          $display("[TB] FAIL strobe_byte: got data=%h grant=%b, required data=%h grant=%b",
                   bus.o_tx_data, bus.o_grant, ed, eg);
        end
      end
    end
    prevStrobe = (bus.o_tx_strobe === 1'b1);
    if (txBusyLeft > 0) begin
      txBusyLeft--;
    end else if (txWait > 0) begin
      txWait--;
      if (txWait == 0) txBusyLeft = txLen;
    end
    if (bus.o_tx_strobe === 1'b1) txWait = txDelay;
    applyStimulus();
  endtask

  task automatic clearModel();
    for (int k = 0; k < NR; k++) begin
      reqBytes[k].delete();
      reqLasts[k].delete();
      reqEn[k] = 1'b1;
    end
    expData.delete();
    expGrant.delete();
    obsGrant.delete();
    txWait      = 0;
    txBusyLeft  = 0;
    txForce     = 1'b0;
    prevStrobe  = 1'b0;
    strobeCount = 0;
    modelPtr    = 0;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    clearModel();
    applyStimulus();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic addPacket(input int k, input int len, input logic [7:0] first, input bit randomData);
    for (int i = 0; i < len; i++) begin
      reqBytes[k].push_back(randomData ? 8'($urandom) : first + 8'(i));
      reqLasts[k].push_back(i == len - 1);
    end
  endtask

  // Whole packets in round-robin order from modelPtr; a burst limit splits a packet across grants.
  function automatic void buildExpected();
    int pos[NR];
    int owner, c, cnt;
    bit endG;
    logic [NR-1:0] g;
    for (int k = 0; k < NR; k++) pos[k] = 0;
    while (1) begin
      owner = -1;
      for (int i = 0; i < NR; i++) begin
        c = (modelPtr + i) % NR;
        if (owner < 0 && pos[c] < reqBytes[c].size()) owner = c;
      end
      if (owner < 0) break;
      g = '0;
      g[owner] = 1'b1;
      cnt  = 0;
      endG = 1'b0;
      while (!endG) begin
        expData.push_back(reqBytes[owner][pos[owner]]);
        expGrant.push_back(g);
        cnt++;
        endG = reqLasts[owner][pos[owner]] || (BurstEn && cnt == MB);
        pos[owner]++;
        if (pos[owner] >= reqBytes[owner].size()) endG = 1'b1;
      end
      modelPtr = (owner + 1) % NR;
    end
  endfunction

  function automatic bit pending();
    pending = 1'b0;
    for (int k = 0; k < NR; k++) if (reqBytes[k].size() > 0) pending = 1'b1;
  endfunction

  task automatic drain(input int budget, output bit timedOut);
    int cyc = 0;
    while ((pending() || bus.o_active === 1'b1 || txWait > 0 || txBusyLeft > 0) && cyc < budget) begin
      tick();
      cyc++;
    end
    timedOut = (cyc >= budget);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_req_valid = '1;
    bus.i_tx_busy   = 1'b0;
    @(posedge clk);
    #1;
    assertCount++;
    if (bus.o_grant !== 4'b0000) begin failCount++; $display("[TB] FAIL reset_grant: got %b, required 0000", bus.o_grant); end
    assertCount++;
    if (bus.o_tx_strobe !== 1'b0) begin failCount++; $display("[TB] FAIL reset_strobe: got %b, required 0", bus.o_tx_strobe); end
    assertCount++;
    if (bus.o_tx_data !== 8'h00) begin failCount++; $display("[TB] FAIL reset_data: got %h, required 00", bus.o_tx_data); end
    assertCount++;
    if (bus.o_active !== 1'b0) begin failCount++; $display("[TB] FAIL reset_active: got %b, required 0", bus.o_active); end
    assertCount++;
    if (bus.o_req_ready !== 4'b0000) begin failCount++; $display("[TB] FAIL reset_ready: got %b, required 0000", bus.o_req_ready); end
    applyReset();
    tick();
    assertCount++;
    if (bus.o_active !== 1'b0) begin failCount++; $display("[TB] FAIL reset_idle: active=%b, required 0", bus.o_active); end
  endtask

  task automatic test_single_packet();
    bit to;
    applyReset();
    txDelay = 1;
    txLen   = 10;
    addPacket(0, 3, 8'hA1, 1'b0);
    buildExpected();
    applyStimulus();
    tick();
    assertCount++;
    if (bus.o_grant !== 4'b0001 || bus.o_active !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL single_first_grant: grant=%b active=%b, required 0001 1", bus.o_grant, bus.o_active);
    end
    drain(500, to);
    assertCount++;
    if (to || expData.size() != 0 || strobeCount != 3 || bus.o_grant !== 4'b0000 || bus.o_active !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL single_end: timeout=%0d missing=%0d strobes=%0d grant=%b active=%b, required 0 0 3 0000 0",
               to, expData.size(), strobeCount, bus.o_grant, bus.o_active);
    end
  endtask

  task automatic test_round_robin();
    bit to;
    applyReset();
    txDelay = 2;
    txLen   = 4;
    addPacket(1, 2, 8'h10, 1'b0);
    addPacket(3, 1, 8'h30, 1'b0);
    addPacket(1, 2, 8'h12, 1'b0);
    addPacket(3, 1, 8'h31, 1'b0);
    buildExpected();
    applyStimulus();
    tick();
    assertCount++;
    if (bus.o_grant !== 4'b0010) begin failCount++; $display("[TB] FAIL rr_first_grant: got %b, required 0010", bus.o_grant); end
    drain(1000, to);
    assertCount++;
    if (to || expData.size() != 0 || obsGrant.size() != 6 || obsGrant[2] !== 4'b1000 || obsGrant[3] !== 4'b0010) begin
      failCount++;
      $display("[TB] FAIL rr_end: timeout=%0d missing=%0d strobes=%0d, required 0 0 6 with req3 then req1 in the middle",
               to, expData.size(), obsGrant.size());
    end
  endtask

  task automatic test_busy_on_entry();
    bit to;
    applyReset();
    txDelay = 1;
    txLen   = 3;
    txForce = 1'b1;
    addPacket(2, 1, 8'h5C, 1'b0);
    buildExpected();
    applyStimulus();
    tick();
    assertCount++;
    if (bus.o_grant !== 4'b0100) begin failCount++; $display("[TB] FAIL busy_grant: got %b, required 0100", bus.o_grant); end
    for (int i = 0; i < 6; i++) begin
      tick();
      assertCount++;
      if (bus.o_req_ready !== 4'b0000 || strobeCount != 0) begin
        failCount++;
        $display("[TB] FAIL busy_hold: ready=%b strobes=%0d, required 0000 0", bus.o_req_ready, strobeCount);
      end
    end
    txForce = 1'b0;
    applyStimulus();
    #1;
    assertCount++;
    if (bus.o_req_ready !== 4'b0100) begin failCount++; $display("[TB] FAIL busy_release_ready: got %b, required 0100", bus.o_req_ready); end
    tick();
    assertCount++;
    if (strobeCount != 1) begin failCount++; $display("[TB] FAIL busy_release_strobe: strobes=%0d, required 1", strobeCount); end
    drain(200, to);
    assertCount++;
    if (to || expData.size() != 0 || bus.o_active !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL busy_end: timeout=%0d missing=%0d active=%b, required 0 0 0", to, expData.size(), bus.o_active);
    end
  endtask

  task automatic test_burst();
    bit to;
    int firstReq2;
    applyReset();
    txDelay = 1;
    txLen   = 3;
    addPacket(0, 10, 8'h40, 1'b0);
    addPacket(2, 2, 8'hE0, 1'b0);
    buildExpected();
    applyStimulus();
    drain(2000, to);
    firstReq2 = -1;
    for (int i = obsGrant.size() - 1; i >= 0; i--) if (obsGrant[i] === 4'b0100) firstReq2 = i;
    assertCount++;
    if (to || expData.size() != 0 || firstReq2 != (BurstEn ? 4 : 10)) begin
      failCount++;
      $display("[TB] FAIL burst_order: timeout=%0d missing=%0d first req2 byte at %0d, required 0 0 %0d",
               to, expData.size(), firstReq2, BurstEn ? 4 : 10);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int cyc = 0;
    applyReset();
    txDelay = 1;
    txLen   = 8;
    addPacket(0, 4, 8'h80, 1'b0);
    addPacket(3, 1, 8'h90, 1'b0);
    buildExpected();
    applyStimulus();
    while (!(strobeCount >= 1 && txBusyLeft > 0 && txBusyLeft < txLen - 1) && cyc < 100) begin
      tick();
      cyc++;
    end
    assertCount++;
    if (cyc >= 100) begin failCount++; $display("[TB] FAIL midreset_reach: cycles=%0d, required under 100", cyc); end
    rst = 1'b1;
    #1;
    assertCount++;
    if (bus.o_grant !== 4'b0000 || bus.o_tx_strobe !== 1'b0 || bus.o_tx_data !== 8'h00 || bus.o_active !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midreset_outputs: grant=%b strobe=%b data=%h active=%b, required 0000 0 00 0",
               bus.o_grant, bus.o_tx_strobe, bus.o_tx_data, bus.o_active);
    end
    clearModel();
    applyStimulus();
    repeat (2) tick();
    rst = 1'b0;
    addPacket(0, 1, 8'h77, 1'b0);
    addPacket(3, 1, 8'h33, 1'b0);
    buildExpected();
    applyStimulus();
    tick();
    assertCount++;
    if (bus.o_grant !== 4'b0001) begin failCount++; $display("[TB] FAIL midreset_regrant: got %b, required 0001", bus.o_grant); end
    drain(500, to);
    assertCount++;
    if (to || expData.size() != 0 || strobeCount != 2) begin
      failCount++;
      $display("[TB] FAIL midreset_end: timeout=%0d missing=%0d strobes=%0d, required 0 0 2", to, expData.size(), strobeCount);
    end
  endtask

  task automatic test_owner_drop();
    bit to;
    int cyc = 0;
    applyReset();
    txDelay = 1;
    txLen   = 3;
    addPacket(0, 4, 8'hC0, 1'b0);
    addPacket(1, 2, 8'hD0, 1'b0);
    buildExpected();
    applyStimulus();
    while (reqBytes[0].size() > 2 && cyc < 200) begin
      tick();
      cyc++;
    end
    reqEn[0] = 1'b0;
    applyStimulus();
    for (int i = 0; i < 50; i++) begin
      tick();
      assertCount++;
      if (bus.o_grant !== 4'b0001 || bus.o_req_ready[1] !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL drop_hold: grant=%b ready1=%b, required 0001 0", bus.o_grant, bus.o_req_ready[1]);
      end
    end
    assertCount++;
    if (strobeCount != 2) begin failCount++; $display("[TB] FAIL drop_strobes: got %0d, required 2", strobeCount); end
    reqEn[0] = 1'b1;
    applyStimulus();
    drain(500, to);
    assertCount++;
    if (to || expData.size() != 0 || strobeCount != 6) begin
      failCount++;
      $display("[TB] FAIL drop_end: timeout=%0d missing=%0d strobes=%0d, required 0 0 6", to, expData.size(), strobeCount);
    end
  endtask

  task automatic test_random();
    bit to;
    int total;
    applyReset();
    for (int iter = 0; iter < 8; iter++) begin
      txDelay = $urandom_range(1, 3);
      txLen   = $urandom_range(1, 6);
      total   = 0;
      for (int k = 0; k < NR; k++) begin
        for (int p = $urandom_range(0, 2); p > 0; p--) begin
          addPacket(k, $urandom_range(1, 6), 8'h00, 1'b1);
          total++;
        end
      end
      if (total == 0) addPacket($urandom_range(0, NR - 1), 3, 8'h00, 1'b1);
      buildExpected();
      applyStimulus();
      drain(5000, to);
      assertCount++;
      if (to || expData.size() != 0 || bus.o_active !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL random_iter%0d: timeout=%0d missing=%0d active=%b, required 0 0 0",
                 iter, to, expData.size(), bus.o_active);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    txDelay = 1;
    txLen   = 1;
    clearModel();
    applyStimulus();
    test_reset();
    test_single_packet();
    test_round_robin();
    test_busy_on_entry();
    test_burst();
    test_reset_mid();
    test_owner_drop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
